// File: rtl/bus_arbiter.sv
// bus_arbiter: hands the 8088 system bus between the CPU (default owner) and
// two DMA masters through a HOLD/HLDA handshake, with round-robin fairness
// between the masters and a bounded tenure per grant.
module bus_arbiter #(
   parameter int unsigned MAX_TENURE = 16,
   parameter int unsigned CPU_MIN    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_rd_n,
   input  logic        cpu_wr_n,
   input  logic        cpu_iom,
   input  logic [19:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   output logic        cpu_hold,
   input  logic        cpu_hlda,
   input  logic [1:0]  dma_req,
   output logic [1:0]  dma_gnt,
   input  logic        dma0_rd_n,
   input  logic        dma0_wr_n,
   input  logic        dma0_iom,
   input  logic [19:0] dma0_addr,
   input  logic [7:0]  dma0_dout,
   input  logic        dma1_rd_n,
   input  logic        dma1_wr_n,
   input  logic        dma1_iom,
   input  logic [19:0] dma1_addr,
   input  logic [7:0]  dma1_dout,
   output logic        bus_rd_n,
   output logic        bus_wr_n,
   output logic        bus_iom,
   output logic [19:0] bus_addr,
   output logic [7:0]  bus_dout,
   output logic [1:0]  bus_owner,
   output logic        bus_err
);

   typedef enum logic [2:0] {
      CPU_OWN,
      HOLD_WAIT,
      DMA0,
      DMA1,
      TURN,
      RELEASE
   } state_e;

   localparam logic [7:0] TEN_LAST = 8'(MAX_TENURE - 1);
   localparam logic [7:0] CPU_SAT  = 8'(CPU_MIN);

   localparam logic [1:0] OWN_CPU  = 2'b00;
   localparam logic [1:0] OWN_DMA0 = 2'b01;
   localparam logic [1:0] OWN_DMA1 = 2'b10;
   localparam logic [1:0] OWN_NONE = 2'b11;

   state_e      state_q, state_d;
   logic        hold_q, hold_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  owner_q, owner_d;
   logic        err_q, err_d;
   logic        last_q, last_d;       // master granted most recently (1 = DMA1)
   logic [7:0]  cpu_cnt_q, cpu_cnt_d;
   logic        cpu_sat_q, cpu_sat_d; // counter treated as saturated out of reset
   logic [7:0]  ten_cnt_q, ten_cnt_d;

   logic        cpu_met;
   logic        cur;
   logic        grant_en;
   logic        grant_sel;
   logic        hlda_lost;

   assign cpu_met   = cpu_sat_q || (cpu_cnt_q == CPU_SAT);

   assign cpu_hold  = hold_q;
   assign dma_gnt   = gnt_q;
   assign bus_owner = owner_q;
   assign bus_err   = err_q;

   // State and registered outputs; async reset returns the bus to the CPU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= CPU_OWN;
         hold_q    <= 1'b0;
         gnt_q     <= '0;
         owner_q   <= OWN_CPU;
         err_q     <= 1'b0;
         last_q    <= 1'b1;
         cpu_cnt_q <= '0;
         cpu_sat_q <= 1'b1;
         ten_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         err_q     <= err_d;
         last_q    <= last_d;
         cpu_cnt_q <= cpu_cnt_d;
         cpu_sat_q <= cpu_sat_d;
         ten_cnt_q <= ten_cnt_d;
      end
   end

   // Next-state and next-output logic; grants and HLDA loss are applied after
   // the case so every path that issues them shares one definition.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      err_d     = err_q;
      last_d    = last_q;
      cpu_cnt_d = cpu_cnt_q;
      cpu_sat_d = cpu_sat_q;
      ten_cnt_d = ten_cnt_q;
      grant_en  = 1'b0;
      grant_sel = 1'b0;
      hlda_lost = 1'b0;
      cur       = (state_q == DMA1);

      unique case (state_q)
         CPU_OWN: begin
            if (!cpu_met) begin
               cpu_cnt_d = cpu_cnt_q + 8'd1;
            end
            if (cpu_met && (dma_req != 2'b00)) begin
               state_d = HOLD_WAIT;
               hold_d  = 1'b1;
            end
         end
         HOLD_WAIT: begin
            if (cpu_hlda) begin
               if (dma_req == 2'b00) begin
                  state_d = RELEASE;
                  owner_d = OWN_NONE;
               end else begin
                  grant_en  = 1'b1;
                  grant_sel = (dma_req == 2'b11) ? ~last_q : dma_req[1];
               end
            end
         end
         DMA0, DMA1: begin
            if (!cpu_hlda) begin
               hlda_lost = 1'b1;
            end else if (!dma_req[cur] || (ten_cnt_q == TEN_LAST)) begin
               gnt_d   = '0;
               owner_d = OWN_NONE;
               state_d = dma_req[~cur] ? TURN : RELEASE;
            end else begin
               ten_cnt_d = ten_cnt_q + 8'd1;
            end
         end
         TURN: begin
            if (!cpu_hlda) begin
               hlda_lost = 1'b1;
            end else begin
               grant_en  = 1'b1;
               grant_sel = ~last_q;
            end
         end
         RELEASE: begin
            state_d   = CPU_OWN;
            hold_d    = 1'b0;
            owner_d   = OWN_CPU;
            cpu_cnt_d = '0;
            cpu_sat_d = 1'b0;
         end
         default: begin
            state_d = CPU_OWN;
         end
      endcase

      if (grant_en) begin
         state_d   = grant_sel ? DMA1 : DMA0;
         gnt_d     = grant_sel ? 2'b10 : 2'b01;
         owner_d   = grant_sel ? OWN_DMA1 : OWN_DMA0;
         last_d    = grant_sel;
         ten_cnt_d = '0;
      end

      if (hlda_lost) begin
         state_d   = CPU_OWN;
         hold_d    = 1'b0;
         gnt_d     = '0;
         owner_d   = OWN_CPU;
         err_d     = 1'b1;
         cpu_cnt_d = '0;
         cpu_sat_d = 1'b0;
      end
   end

   // Master-side bus mux driven from the registered owner code.
   always_comb begin
      bus_rd_n = cpu_rd_n;
      bus_wr_n = cpu_wr_n;
      bus_iom  = cpu_iom;
      bus_addr = cpu_addr;
      bus_dout = cpu_dout;
      unique case (owner_q)
         OWN_DMA0: begin
            bus_rd_n = dma0_rd_n;
            bus_wr_n = dma0_wr_n;
            bus_iom  = dma0_iom;
            bus_addr = dma0_addr;
            bus_dout = dma0_dout;
         end
         OWN_DMA1: begin
            bus_rd_n = dma1_rd_n;
            bus_wr_n = dma1_wr_n;
            bus_iom  = dma1_iom;
            bus_addr = dma1_addr;
            bus_dout = dma1_dout;
         end
         OWN_NONE: begin
            bus_rd_n = 1'b1;
            bus_wr_n = 1'b1;
            bus_iom  = 1'b0;
            bus_addr = '0;
            bus_dout = '0;
         end
         default: begin
            bus_rd_n = cpu_rd_n;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios plus a randomized phase, every cycle
// compared against a behavioural model of the arbitration rules.
module tb_bus_arbiter;

   localparam int unsigned MAXT = 4;
   localparam int unsigned CMIN = 4;

   logic        clk;
   logic        rst;
   logic        cpu_rd_n, cpu_wr_n, cpu_iom;
   logic [19:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_hold;
   logic        cpu_hlda;
   logic [1:0]  dma_req;
   logic [1:0]  dma_gnt;
   logic        dma0_rd_n, dma0_wr_n, dma0_iom;
   logic [19:0] dma0_addr;
   logic [7:0]  dma0_dout;
   logic        dma1_rd_n, dma1_wr_n, dma1_iom;
   logic [19:0] dma1_addr;
   logic [7:0]  dma1_dout;
   logic        bus_rd_n, bus_wr_n, bus_iom;
   logic [19:0] bus_addr;
   logic [7:0]  bus_dout;
   logic [1:0]  bus_owner;
   logic        bus_err;

   int n_vec = 0;
   int n_err = 0;
   logic pin_addr = 1'b0;

   // Reference model: expected registered outputs plus a few spec-level facts.
   logic       e_hold;
   logic [1:0] e_gnt;
   logic [1:0] e_owner;
   logic       e_err;
   int         e_held;   // cycles the current grant has been high
   int         e_age;    // cycles the CPU has held the bus since it got it back
   int         e_prev;   // master granted most recently
   int         e_after;  // during an idle cycle: 1 = back to CPU, 2 = hand over

   bus_arbiter #(.MAX_TENURE(MAXT), .CPU_MIN(CMIN)) dut (
      .clk(clk), .rst(rst),
      .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_iom(cpu_iom),
      .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
      .cpu_hold(cpu_hold), .cpu_hlda(cpu_hlda),
      .dma_req(dma_req), .dma_gnt(dma_gnt),
      .dma0_rd_n(dma0_rd_n), .dma0_wr_n(dma0_wr_n), .dma0_iom(dma0_iom),
      .dma0_addr(dma0_addr), .dma0_dout(dma0_dout),
      .dma1_rd_n(dma1_rd_n), .dma1_wr_n(dma1_wr_n), .dma1_iom(dma1_iom),
      .dma1_addr(dma1_addr), .dma1_dout(dma1_dout),
      .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n), .bus_iom(bus_iom),
      .bus_addr(bus_addr), .bus_dout(bus_dout),
      .bus_owner(bus_owner), .bus_err(bus_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      e_hold  = 1'b0;
      e_gnt   = 2'b00;
      e_owner = 2'b00;
      e_err   = 1'b0;
      e_held  = 0;
      e_age   = CMIN;
      e_prev  = 1;
      e_after = 0;
   endtask

   task automatic give(input int w);
      e_gnt   = (w == 0) ? 2'b01 : 2'b10;
      e_owner = (w == 0) ? 2'b01 : 2'b10;
      e_held  = 1;
      e_prev  = w;
   endtask

   task automatic go_lost();
      e_gnt   = 2'b00;
      e_hold  = 1'b0;
      e_owner = 2'b00;
      e_err   = 1'b1;
      e_age   = 0;
   endtask

   task automatic model_step(input logic [1:0] req, input logic hlda);
      int who;
      if (e_owner == 2'b01 || e_owner == 2'b10) begin
         who = (e_owner == 2'b01) ? 0 : 1;
         if (!hlda) go_lost();
         else if (!req[who] || e_held == MAXT) begin
            e_gnt   = 2'b00;
            e_owner = 2'b11;
            e_after = req[1 - who] ? 2 : 1;
         end else e_held++;
      end else if (e_owner == 2'b11) begin
         if (e_after == 2) begin
            if (!hlda) go_lost();
            else give(1 - e_prev);
         end else begin
            e_hold  = 1'b0;
            e_owner = 2'b00;
            e_age   = 0;
         end
      end else if (e_hold) begin
         if (hlda) begin
            if (req == 2'b00) begin
               e_owner = 2'b11;
               e_after = 1;
            end else if (req == 2'b11) give(1 - e_prev);
            else give(req[1] ? 1 : 0);
         end
      end else begin
         if (e_age >= CMIN && req != 2'b00) e_hold = 1'b1;
         else if (e_age < CMIN) e_age++;
      end
   endtask

   task automatic check_model();
      logic [19:0] xa;
      logic [7:0]  xd;
      logic [2:0]  xs;
      case (e_owner)
         2'b01: begin xa = dma0_addr; xd = dma0_dout; xs = {dma0_rd_n, dma0_wr_n, dma0_iom}; end
         2'b10: begin xa = dma1_addr; xd = dma1_dout; xs = {dma1_rd_n, dma1_wr_n, dma1_iom}; end
         2'b11: begin xa = '0; xd = '0; xs = 3'b110; end
         default: begin xa = cpu_addr; xd = cpu_dout; xs = {cpu_rd_n, cpu_wr_n, cpu_iom}; end
      endcase
      chk("hold",   32'(cpu_hold),  32'(e_hold));
      chk("gnt",    32'(dma_gnt),   32'(e_gnt));
      chk("owner",  32'(bus_owner), 32'(e_owner));
      chk("err",    32'(bus_err),   32'(e_err));
      chk("addr",   32'(bus_addr),  32'(xa));
      chk("dout",   32'(bus_dout),  32'(xd));
      chk("strobe", 32'({bus_rd_n, bus_wr_n, bus_iom}), 32'(xs));
   endtask

   task automatic rand_bus();
      cpu_rd_n  = 1'($urandom); cpu_wr_n  = 1'($urandom); cpu_iom  = 1'($urandom);
      cpu_addr  = 20'($urandom); cpu_dout = 8'($urandom);
      dma0_rd_n = 1'($urandom); dma0_wr_n = 1'($urandom); dma0_iom = 1'($urandom);
      dma0_addr = 20'($urandom); dma0_dout = 8'($urandom);
      dma1_rd_n = 1'($urandom); dma1_wr_n = 1'($urandom); dma1_iom = 1'($urandom);
      dma1_addr = 20'($urandom); dma1_dout = 8'($urandom);
      if (pin_addr) dma0_addr = 20'h01234;
   endtask

   task automatic tick();
      rand_bus();
      @(posedge clk);
      if (rst) model_reset();
      else model_step(dma_req, cpu_hlda);
      #1;
      check_model();
   endtask

   task automatic wait_hold(input string tag, output int n);
      n = 0;
      while (cpu_hold !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(cpu_hold), 32'd1);
   endtask

   initial begin
      int n;
      logic [1:0] xg;
      model_reset();
      rst = 1'b1;
      dma_req = 2'b00;
      cpu_hlda = 1'b0;
      rand_bus();

      // Reset state
      tick();
      tick();
      chk("rst_hold",  32'(cpu_hold),  32'd0);
      chk("rst_gnt",   32'(dma_gnt),   32'd0);
      chk("rst_owner", 32'(bus_owner), 32'd0);
      chk("rst_err",   32'(bus_err),   32'd0);
      chk("rst_addr",  32'(bus_addr),  32'(cpu_addr));
      rst = 1'b0;

      // Single request from DMA0, HLDA two cycles after HOLD
      pin_addr = 1'b1;
      dma_req = 2'b01;
      tick();
      chk("t1_hold_up", 32'(cpu_hold), 32'd1);
      chk("t1_no_gnt",  32'(dma_gnt),  32'd0);
      tick();
      tick();
      cpu_hlda = 1'b1;
      tick();
      chk("t1_gnt",   32'(dma_gnt),   32'h1);
      chk("t1_owner", 32'(bus_owner), 32'h1);
      chk("t1_addr",  32'(bus_addr),  32'h01234);
      tick();
      dma_req = 2'b00;
      tick();
      chk("t1_idle_owner", 32'(bus_owner), 32'h3);
      chk("t1_idle_gnt",   32'(dma_gnt),   32'h0);
      chk("t1_idle_hold",  32'(cpu_hold),  32'h1);
      tick();
      chk("t1_rel_hold",  32'(cpu_hold),  32'h0);
      chk("t1_rel_owner", 32'(bus_owner), 32'h0);
      cpu_hlda = 1'b0;

      // Immediate re-request: CPU keeps the bus at least CPU_MIN cycles
      dma_req = 2'b01;
      wait_hold("t3_hold", n);
      chk("t3_cpu_min", 32'(n >= int'(CMIN)), 32'd1);
      cpu_hlda = 1'b1;
      tick();
      chk("t3_gnt", 32'(dma_gnt), 32'h1);
      dma_req = 2'b00;
      tick();
      tick();
      cpu_hlda = 1'b0;
      pin_addr = 1'b0;

      // Both masters continuously: DMA0 was last, so DMA1 leads, then alternate
      dma_req = 2'b11;
      wait_hold("t2_hold", n);
      cpu_hlda = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (i % 5 == 4) xg = 2'b00;
         else if ((i / 5) % 2 == 0) xg = 2'b10;
         else xg = 2'b01;
         chk("t2_gnt", 32'(dma_gnt), 32'(xg));
         chk("t2_hold_high", 32'(cpu_hold), 32'd1);
      end
      dma_req = 2'b00;
      tick();
      tick();
      tick();
      cpu_hlda = 1'b0;
      tick();

      // Requests withdrawn while waiting for HLDA
      dma_req = 2'b10;
      wait_hold("t5_hold", n);
      dma_req = 2'b00;
      tick();
      chk("t5_wait_owner", 32'(bus_owner), 32'h0);
      chk("t5_wait_hold",  32'(cpu_hold),  32'h1);
      cpu_hlda = 1'b1;
      tick();
      chk("t5_nogrant",  32'(dma_gnt),   32'h0);
      chk("t5_rel_idle", 32'(bus_owner), 32'h3);
      tick();
      chk("t5_back_hold",  32'(cpu_hold),  32'h0);
      chk("t5_back_owner", 32'(bus_owner), 32'h0);
      chk("t5_back_gnt",   32'(dma_gnt),   32'h0);
      cpu_hlda = 1'b0;

      // Randomized traffic with a CPU that answers HOLD after a random delay
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(3, 0) == 0) dma_req = 2'($urandom);
         if (e_hold && !cpu_hlda && $urandom_range(1, 0) == 1) cpu_hlda = 1'b1;
         else if (!e_hold && cpu_hlda && $urandom_range(1, 0) == 1) cpu_hlda = 1'b0;
         else if (e_owner != 2'b00 && e_hold && cpu_hlda && $urandom_range(199, 0) == 0)
            cpu_hlda = 1'b0;
         tick();
      end
      dma_req = 2'b00;
      for (int c = 0; c < 10; c++) begin
         cpu_hlda = e_hold;
         tick();
      end
      cpu_hlda = 1'b0;

      // HLDA dropped mid-grant
      dma_req = 2'b01;
      wait_hold("t4_hold", n);
      cpu_hlda = 1'b1;
      tick();
      tick();
      cpu_hlda = 1'b0;
      tick();
      chk("t4_gnt",   32'(dma_gnt),   32'h0);
      chk("t4_hold",  32'(cpu_hold),  32'h0);
      chk("t4_owner", 32'(bus_owner), 32'h0);
      chk("t4_err",   32'(bus_err),   32'h1);
      dma_req = 2'b00;
      tick();
      tick();
      tick();
      chk("t4_sticky", 32'(bus_err), 32'h1);

      // Asynchronous reset during a DMA1 grant
      dma_req = 2'b10;
      wait_hold("t6_hold", n);
      cpu_hlda = 1'b1;
      tick();
      chk("t6_dma1", 32'(dma_gnt), 32'h2);
      tick();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("t6_rst_hold",  32'(cpu_hold),  32'h0);
      chk("t6_rst_gnt",   32'(dma_gnt),   32'h0);
      chk("t6_rst_owner", 32'(bus_owner), 32'h0);
      chk("t6_rst_err",   32'(bus_err),   32'h0);
      chk("t6_rst_addr",  32'(bus_addr),  32'(cpu_addr));
      check_model();
      #1;
      rst = 1'b0;
      cpu_hlda = 1'b0;
      dma_req = 2'b11;
      tick();
      chk("t6_hold_up", 32'(cpu_hold), 32'h1);
      cpu_hlda = 1'b1;
      tick();
      chk("t6_first_dma0", 32'(dma_gnt), 32'h1);
      dma_req = 2'b00;
      tick();
      tick();
      cpu_hlda = 1'b0;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
